cpu_cmd_sequencer: RTL and testbench
====================================

Name: cpu_cmd_sequencer

Overview:
- Upstream issue stage for the CPU datapath top.
- Accepts host commands (7-bit cmd plus four WIDTH-bit operands) over a valid/ready interface and buffers them in a small FIFO.
- Presents one command at a time on the CPU's cmd_in and din_1..din_4, paced by cpu_rdy.
- Captures out_reg3, zero and error into a result register returned to the host over a valid/ready interface.

Parameters:
- WIDTH, 8: operand width; result width is 2*WIDTH.
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- TIMEOUT, 16: cycles to wait for each cpu_rdy edge before aborting a command.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- host_valid  in  1  host command valid.
- host_ready  out  1  FIFO not full.
- host_cmd  in  7  command word; passed through opaque.
- host_d1..host_d4  in  WIDTH each  operands.
- cmd_out  out  7  to CPU cmd_in; 7'h00 = NOP.
- dout_1..dout_4  out  WIDTH each  to CPU din_1..din_4.
- cpu_rdy  in  1  CPU idle/done.
- cpu_result  in  2*WIDTH  CPU out_reg3.
- cpu_zero, cpu_error  in  1 each  CPU flags.
- res_valid  out  1  result available.
- res_ready  in  1  host consumes result.
- res_data  out  2*WIDTH  captured result.
- res_zero, res_error  out  1 each  captured flags.
- res_timeout  out  1  result aborted by watchdog.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (synchronous, active-high) values:
  - FIFO empty; host_ready=1.
  - cmd_out=0; dout_*=0.
  - res_valid=0; res_data=0; res_zero=0; res_error=0; res_timeout=0.
  - busy=0; FSM in IDLE.
  - Reset mid-command discards the FIFO contents and any pending result. CPU state is not touched (it shares reset).
- FIFO:
  - Push when host_valid && host_ready.
  - Pop only on the IDLE->ISSUE transition.
  - Push while full is ignored; host_ready=0 prevents it.
  - Simultaneous push and pop when full is allowed: occupancy is unchanged.
  - Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESULT.
  - IDLE: leave when FIFO non-empty && cpu_rdy && !res_valid. Pop the entry and register cmd_out and dout_* from it. Next state ISSUE.
  - ISSUE: hold cmd_out and dout_* for one cycle, then go to WAIT_ACK.
  - WAIT_ACK: hold cmd_out and dout_*.
    - cpu_rdy==0: CPU has accepted the command. Set cmd_out=0 next cycle and go to WAIT_DONE. dout_* hold their last value.
  - WAIT_DONE:
    - cpu_rdy==1: next cycle capture res_data=cpu_result, res_zero=cpu_zero, res_error=cpu_error, res_timeout=0. Go to RESULT.
  - RESULT: assert res_valid, then go to IDLE in the following cycle.
- Result handshake:
  - res_valid stays high until res_valid && res_ready, then clears the next cycle.
  - res_* are stable while res_valid=1.
  - No new command issues while res_valid=1.
- Latency: the first host push into an empty FIFO with cpu_rdy=1 gives cmd_out valid 2 cycles later (push cycle + pop cycle).
- Watchdog (see Optional Feature):
  - Counter resets on entering WAIT_ACK and again on entering WAIT_DONE.
  - Counter reaching TIMEOUT aborts the command:
    - cmd_out=0.
    - res_valid=1, res_timeout=1, res_data=0, res_error=1.
    - Go to IDLE.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: CPU_SEQ_WATCHDOG_EN.
- Defined: the watchdog counter and timeout abort are present; res_timeout is functional.
- Undefined: no counter; WAIT_ACK and WAIT_DONE wait indefinitely; res_timeout is tied to 0.

Decomposition:
- Package cpu_seq_pkg holds:
  - state enum seq_state_t.
  - struct seq_entry_t {cmd[6:0], d1..d4}.
  - localparam CMD_NOP=7'h00.
- Sub-module cpu_seq_fifo: DEPTH-entry synchronous FIFO of seq_entry_t with push/pop/full/empty. The FSM and result register stay in cpu_cmd_sequencer.

Test Plan:
1. Reset, then one push with host_cmd=7'h15, host_d1..d4=8'h03,8'h05,8'h00,8'h00. Hold cpu_rdy=1; drop it 2 cycles after cmd_out=7'h15; raise it 5 cycles later with cpu_result=16'h0008, cpu_zero=0 -> res_valid=1, res_data=16'h0008, res_zero=0, res_timeout=0; cmd_out back to 7'h00 after the ack.
2. Push 5 commands back-to-back with DEPTH=4 and cpu_rdy=1 held -> host_ready=0 after the 4th push. The 5th is accepted only after the first pop. Commands issue in push order.
3. Hold res_ready=0 across two queued commands -> the second command does not issue until res_ready=1 for one cycle; res_data is stable meanwhile.
4. With CPU_SEQ_WATCHDOG_EN and TIMEOUT=16, never drop cpu_rdy after issue -> 16 cycles into WAIT_ACK: res_timeout=1, res_error=1, res_data=0, cmd_out=0. The next queued command then issues.
5. Assert reset during WAIT_DONE with 2 entries queued -> the next cycle shows all outputs at reset values and host_ready=1; no result is produced.
6. CPU reports cpu_error=1 and cpu_zero=1 with cpu_result=16'h0000 -> res_error=1, res_zero=1, res_timeout=0.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared types for the CPU command sequencer: FSM state, FIFO entry layout, NOP encoding.
package cpu_seq_pkg;

  localparam int unsigned SEQ_WIDTH = 8;
  localparam int unsigned CMD_W     = 7;

  localparam logic [CMD_W-1:0] CMD_NOP = 7'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_RESULT
  } seq_state_t;

  typedef struct packed {
    logic [CMD_W-1:0]     cmd;
    logic [SEQ_WIDTH-1:0] d1;
    logic [SEQ_WIDTH-1:0] d2;
    logic [SEQ_WIDTH-1:0] d3;
    logic [SEQ_WIDTH-1:0] d4;
  } seq_entry_t;

endpackage

// File: rtl/cpu_seq_fifo.sv
// DEPTH-entry synchronous FIFO of seq_entry_t; full/empty are registered flags.
module cpu_seq_fifo
  import cpu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  seq_entry_t wdata,
  output seq_entry_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  seq_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/cpu_cmd_sequencer.sv
// Issue stage in front of the CPU datapath: queues host commands, paces them by cpu_rdy,
// returns captured results. Optional watchdog abort enabled by `define CPU_SEQ_WATCHDOG_EN.
module cpu_cmd_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = SEQ_WIDTH,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [6:0]         host_cmd,
  input  logic [WIDTH-1:0]   host_d1,
  input  logic [WIDTH-1:0]   host_d2,
  input  logic [WIDTH-1:0]   host_d3,
  input  logic [WIDTH-1:0]   host_d4,
  output logic [6:0]         cmd_out,
  output logic [WIDTH-1:0]   dout_1,
  output logic [WIDTH-1:0]   dout_2,
  output logic [WIDTH-1:0]   dout_3,
  output logic [WIDTH-1:0]   dout_4,
  input  logic               cpu_rdy,
  input  logic [2*WIDTH-1:0] cpu_result,
  input  logic               cpu_zero,
  input  logic               cpu_error,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic               res_zero,
  output logic               res_error,
  output logic               res_timeout,
  output logic               busy
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cpu_cmd_sequencer: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("cpu_cmd_sequencer: TIMEOUT must be >= 1");
  end

  seq_state_t state;
  seq_state_t state_nxt;
  seq_entry_t wentry;
  seq_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       clr_cmd;
  logic       cap;
  logic       abort;
  logic       wd_expired;

  assign host_ready = !fifo_full;

  assign wentry = '{cmd: host_cmd,
                    d1:  SEQ_WIDTH'(host_d1),
                    d2:  SEQ_WIDTH'(host_d2),
                    d3:  SEQ_WIDTH'(host_d3),
                    d4:  SEQ_WIDTH'(host_d4)};

  cpu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (host_valid && host_ready),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Ack (cpu_rdy low) wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (!fifo_empty && cpu_rdy && !res_valid) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_ACK;
      S_WAIT_ACK:  if (!cpu_rdy) state_nxt = S_WAIT_DONE;
                   else if (wd_expired) state_nxt = S_IDLE;
      S_WAIT_DONE: if (cpu_rdy) state_nxt = S_RESULT;
                   else if (wd_expired) state_nxt = S_IDLE;
      S_RESULT:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    clr_cmd = 1'b0;
    cap     = 1'b0;
    abort   = 1'b0;
    case (state)
      S_IDLE:      pop = (state_nxt == S_ISSUE);
      S_WAIT_ACK: begin
        clr_cmd = !cpu_rdy || wd_expired;
        abort   = cpu_rdy && wd_expired;
      end
      S_WAIT_DONE: begin
        cap     = cpu_rdy;
        abort   = !cpu_rdy && wd_expired;
        clr_cmd = !cpu_rdy && wd_expired;
      end
      default: ;
    endcase
  end

`ifdef CPU_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  // Restarts on every state change, so it measures time spent in the current wait state.
  always_ff @(posedge clk) begin
    if (reset)                                             wd_cnt <= '0;
    else if (state_nxt != state)                           wd_cnt <= '0;
    else if (state == S_WAIT_ACK || state == S_WAIT_DONE)  wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_out     <= CMD_NOP;
      dout_1      <= '0;
      dout_2      <= '0;
      dout_3      <= '0;
      dout_4      <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_zero    <= 1'b0;
      res_error   <= 1'b0;
      res_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (pop) begin
        cmd_out <= head.cmd;
        dout_1  <= WIDTH'(head.d1);
        dout_2  <= WIDTH'(head.d2);
        dout_3  <= WIDTH'(head.d3);
        dout_4  <= WIDTH'(head.d4);
      end else if (clr_cmd) begin
        cmd_out <= CMD_NOP;
      end

      if (cap) begin
        res_valid   <= 1'b1;
        res_data    <= cpu_result;
        res_zero    <= cpu_zero;
        res_error   <= cpu_error;
        res_timeout <= 1'b0;
      end else if (abort) begin
        res_valid   <= 1'b1;
        res_data    <= '0;
        res_zero    <= 1'b0;
        res_error   <= 1'b1;
        res_timeout <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      busy <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// Directed self-checking bench for cpu_cmd_sequencer; the CPU side is driven by hand.
module tb_cpu_cmd_sequencer;

  localparam int unsigned WIDTH = 8;

  logic               clk;
  logic               reset;
  logic               host_valid;
  logic               host_ready;
  logic [6:0]         host_cmd;
  logic [WIDTH-1:0]   host_d1, host_d2, host_d3, host_d4;
  logic [6:0]         cmd_out;
  logic [WIDTH-1:0]   dout_1, dout_2, dout_3, dout_4;
  logic               cpu_rdy;
  logic [2*WIDTH-1:0] cpu_result;
  logic               cpu_zero;
  logic               cpu_error;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] res_data;
  logic               res_zero;
  logic               res_error;
  logic               res_timeout;
  logic               busy;

  int n_checks = 0;
  int n_pass   = 0;

  cpu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_cmd    (host_cmd),
    .host_d1     (host_d1),
    .host_d2     (host_d2),
    .host_d3     (host_d3),
    .host_d4     (host_d4),
    .cmd_out     (cmd_out),
    .dout_1      (dout_1),
    .dout_2      (dout_2),
    .dout_3      (dout_3),
    .dout_4      (dout_4),
    .cpu_rdy     (cpu_rdy),
    .cpu_result  (cpu_result),
    .cpu_zero    (cpu_zero),
    .cpu_error   (cpu_error),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_zero    (res_zero),
    .res_error   (res_error),
    .res_timeout (res_timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle push; operands are d, d+1, d+2, d+3.
  task automatic push(input logic [6:0] c, input logic [7:0] d);
    host_valid = 1'b1;
    host_cmd   = c;
    host_d1    = d;
    host_d2    = d + 8'd1;
    host_d3    = d + 8'd2;
    host_d4    = d + 8'd3;
    tick();
    host_valid = 1'b0;
  endtask

  // Waits (bounded) for command c, then plays the CPU ack/done sequence and consumes the result.
  task automatic do_cmd(input string tag, input logic [6:0] c, input logic [7:0] d,
                        input logic [15:0] r, input logic z, input logic e);
    for (int i = 0; i < 8 && cmd_out != c; i++) tick();
    check({tag, "_cmd"}, 32'(cmd_out), 32'(c));
    check({tag, "_d1"}, 32'(dout_1), 32'(d));
    check({tag, "_d4"}, 32'(dout_4), 32'(d + 8'd3));
    cpu_rdy = 1'b0;
    tick();
    tick();
    check({tag, "_nop"}, 32'(cmd_out), 32'h0);
    cpu_rdy    = 1'b1;
    cpu_result = r;
    cpu_zero   = z;
    cpu_error  = e;
    tick();
    check({tag, "_rv"}, 32'(res_valid), 32'h1);
    check({tag, "_rd"}, 32'(res_data), 32'(r));
    check({tag, "_rz"}, 32'(res_zero), 32'(z));
    check({tag, "_re"}, 32'(res_error), 32'(e));
    check({tag, "_rt"}, 32'(res_timeout), 32'h0);
    cpu_zero  = 1'b0;
    cpu_error = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_rv_clr"}, 32'(res_valid), 32'h0);
  endtask

  initial begin
    reset = 1'b1; host_valid = 1'b0; host_cmd = '0;
    host_d1 = '0; host_d2 = '0; host_d3 = '0; host_d4 = '0;
    cpu_rdy = 1'b1; cpu_result = '0; cpu_zero = 1'b0; cpu_error = 1'b0; res_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_host_ready", 32'(host_ready), 32'h1);
    check("rst_cmd_out", 32'(cmd_out), 32'h0);
    check("rst_dout_1", 32'(dout_1), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_data", 32'(res_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Test 1: single command, two-cycle latency, ack/done pacing.
    host_valid = 1'b1; host_cmd = 7'h15;
    host_d1 = 8'h03; host_d2 = 8'h05; host_d3 = 8'h00; host_d4 = 8'h00;
    tick();
    host_valid = 1'b0;
    check("t1_lat_cmd", 32'(cmd_out), 32'h0);
    tick();
    check("t1_cmd", 32'(cmd_out), 32'h15);
    check("t1_d1", 32'(dout_1), 32'h03);
    check("t1_d2", 32'(dout_2), 32'h05);
    check("t1_busy", 32'(busy), 32'h1);
    tick();
    tick();
    cpu_rdy = 1'b0;
    check("t1_hold", 32'(cmd_out), 32'h15);
    tick();
    check("t1_nop", 32'(cmd_out), 32'h0);
    check("t1_d1_hold", 32'(dout_1), 32'h03);
    for (int i = 0; i < 4; i++) tick();
    check("t1_no_res", 32'(res_valid), 32'h0);
    cpu_rdy = 1'b1; cpu_result = 16'h0008;
    tick();
    check("t1_rv", 32'(res_valid), 32'h1);
    check("t1_rd", 32'(res_data), 32'h0008);
    check("t1_rz", 32'(res_zero), 32'h0);
    check("t1_rt", 32'(res_timeout), 32'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t1_rv_clr", 32'(res_valid), 32'h0);
    tick();
    check("t1_idle", 32'(busy), 32'h0);

    // Test 2: fill the FIFO while the CPU is busy; fifth push waits for the first pop.
    cpu_rdy = 1'b0;
    push(7'h21, 8'h10);
    push(7'h22, 8'h20);
    push(7'h23, 8'h30);
    push(7'h24, 8'h40);
    check("t2_full", 32'(host_ready), 32'h0);
    host_valid = 1'b1; host_cmd = 7'h25;
    host_d1 = 8'h50; host_d2 = 8'h51; host_d3 = 8'h52; host_d4 = 8'h53;
    tick();
    check("t2_full_hold", 32'(host_ready), 32'h0);
    check("t2_no_issue", 32'(cmd_out), 32'h0);
    cpu_rdy = 1'b1;
    tick();
    check("t2_first", 32'(cmd_out), 32'h21);
    check("t2_space", 32'(host_ready), 32'h1);
    tick();
    host_valid = 1'b0;
    check("t2_full_again", 32'(host_ready), 32'h0);
    do_cmd("t2a", 7'h21, 8'h10, 16'h0101, 1'b0, 1'b0);
    do_cmd("t2b", 7'h22, 8'h20, 16'h0202, 1'b0, 1'b0);
    do_cmd("t2c", 7'h23, 8'h30, 16'h0303, 1'b0, 1'b0);
    do_cmd("t2d", 7'h24, 8'h40, 16'h0404, 1'b0, 1'b0);
    do_cmd("t2e", 7'h25, 8'h50, 16'h0505, 1'b0, 1'b0);

    // Test 3: pending result blocks the next issue.
    push(7'h31, 8'h60);
    push(7'h32, 8'h70);
    for (int i = 0; i < 8 && cmd_out != 7'h31; i++) tick();
    check("t3_first", 32'(cmd_out), 32'h31);
    cpu_rdy = 1'b0;
    tick();
    tick();
    cpu_rdy = 1'b1; cpu_result = 16'hBEEF;
    tick();
    check("t3_rv", 32'(res_valid), 32'h1);
    for (int i = 0; i < 4; i++) tick();
    check("t3_stall_cmd", 32'(cmd_out), 32'h0);
    check("t3_stall_rv", 32'(res_valid), 32'h1);
    check("t3_stable_rd", 32'(res_data), 32'hBEEF);
    check("t3_stall_busy", 32'(busy), 32'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t3_rv_clr", 32'(res_valid), 32'h0);
    tick();
    check("t3_second", 32'(cmd_out), 32'h32);
    do_cmd("t3b", 7'h32, 8'h70, 16'h1234, 1'b0, 1'b0);

    // Test 4: CPU never acknowledges.
    push(7'h41, 8'h80);
    push(7'h42, 8'h90);
    for (int i = 0; i < 8 && cmd_out != 7'h41; i++) tick();
    check("t4_issue", 32'(cmd_out), 32'h41);
`ifdef CPU_SEQ_WATCHDOG_EN
    for (int i = 0; i < 16; i++) tick();
    check("t4_pre_to", 32'(res_valid), 32'h0);
    tick();
    check("t4_rv", 32'(res_valid), 32'h1);
    check("t4_rt", 32'(res_timeout), 32'h1);
    check("t4_re", 32'(res_error), 32'h1);
    check("t4_rd", 32'(res_data), 32'h0);
    check("t4_nop", 32'(cmd_out), 32'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`else
    for (int i = 0; i < 20; i++) tick();
    check("t4_wait_rv", 32'(res_valid), 32'h0);
    check("t4_wait_rt", 32'(res_timeout), 32'h0);
    check("t4_wait_busy", 32'(busy), 32'h1);
    check("t4_wait_cmd", 32'(cmd_out), 32'h41);
    do_cmd("t4a", 7'h41, 8'h80, 16'h4141, 1'b0, 1'b0);
`endif
    do_cmd("t4b", 7'h42, 8'h90, 16'h4242, 1'b0, 1'b0);

    // Test 5: reset in WAIT_DONE with two entries queued.
    push(7'h51, 8'hA0);
    push(7'h52, 8'hB0);
    push(7'h53, 8'hC0);
    check("t5_issue", 32'(cmd_out), 32'h51);
    cpu_rdy = 1'b0;
    tick();
    tick();
    check("t5_in_done", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_host_ready", 32'(host_ready), 32'h1);
    check("t5_cmd", 32'(cmd_out), 32'h0);
    check("t5_dout", 32'(dout_1), 32'h0);
    check("t5_rv", 32'(res_valid), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    cpu_rdy = 1'b1; cpu_result = 16'hFFFF;
    for (int i = 0; i < 4; i++) tick();
    check("t5_drained_cmd", 32'(cmd_out), 32'h0);
    check("t5_drained_rv", 32'(res_valid), 32'h0);

    // Test 6: error and zero flags pass through.
    push(7'h61, 8'hD0);
    do_cmd("t6", 7'h61, 8'hD0, 16'h0000, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
